div_seq: RTL and testbench

- Sequencer directly upstream of the unsigned restoring divider core; consumed by the multicycle control unit for DIV.
- Latches signed operands from regs A/B, checks for divide-by-zero, feeds magnitudes to the core, and waits for the core's done pulse.
- Applies MIPS sign rules to quotient/remainder and issues a one-cycle HI/LO write.
- Raises Div0 and watchdog exceptions to the control unit.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_sign_adj.sv | 23 ++
 rtl/div_seq.sv | 140 ++++++++++++++
 tb/tb_div_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the signed DIV sequencer.
//   WIDTH_DEF    - default operand/result width
//   WAIT_MAX_DEF - default watchdog limit, in WAIT cycles (core latency is 33)
//   state_t      - sequencer states
package div_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int WAIT_MAX_DEF = 40;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIXUP,
        WRITE,
        EXC
    } state_t;

endpackage

// File: rtl/div_sign_adj.sv
// div_sign_adj: combinational conditional two's-complement negate.
// Used as |x| on the operand path (neg tied to the MSB) and as the sign
// fix-up on the result path (neg tied to the stored sign flags).
//   din  - value to adjust
//   neg  - 1: output is -din mod 2^WIDTH, 0: output is din
//   dout - adjusted value
module div_sign_adj #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    logic signed [WIDTH-1:0] sdin;
    logic signed [WIDTH-1:0] sneg;

    assign sdin = din;
    // Wraps silently: the most negative value negates to itself.
    assign sneg = -sdin;
    assign dout = neg ? sneg : din;

endmodule

// File: rtl/div_seq.sv
// div_seq: sequencer between the multicycle control unit and the unsigned
// restoring divider core. Latches signed A/B, traps divide-by-zero, hands
// magnitudes to the core, waits (with watchdog) for its done pulse, applies
// the MIPS sign rules and issues a one-cycle HI/LO write.
//   clock, reset      - rising-edge clock, async active-low reset
//   start, A, B       - request (sampled in IDLE only) and signed operands
//   div_start         - one-cycle kick to the core
//   div_a, div_b      - |A|, |B| to the core, stable from ISSUE through WAIT
//   div_done, div_hi,
//   div_lo            - core result pulse, unsigned remainder / quotient
//   busy              - high in every state but IDLE
//   hi_out, lo_out    - signed remainder / quotient, held until next write
//   hilo_write, done  - coincident one-cycle write/completion pulses
//   Div0, err_timeout - one-cycle exceptions
// All outputs come straight from flops.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hilo_write,
    output logic             done,
    output logic             Div0,
    output logic             err_timeout
);

    localparam int               CNT_W    = $clog2(WAIT_MAX + 1);
    // Compare against WAIT_MAX-1 so the expiry edge is the one at which the
    // count would reach WAIT_MAX.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] q_adj;
    logic [WIDTH-1:0] r_adj;
    logic             b_zero;
    logic             accept;
    logic             expire;

    div_sign_adj #(.WIDTH(WIDTH)) u_abs_a (.din(A),     .neg(A[WIDTH-1]), .dout(abs_a));
    div_sign_adj #(.WIDTH(WIDTH)) u_abs_b (.din(B),     .neg(B[WIDTH-1]), .dout(abs_b));
    div_sign_adj #(.WIDTH(WIDTH)) u_adj_q (.din(q_raw), .neg(sa ^ sb),    .dout(q_adj));
    div_sign_adj #(.WIDTH(WIDTH)) u_adj_r (.din(r_raw), .neg(sa),         .dout(r_adj));

    assign b_zero = (B == '0);
    assign accept = (state == IDLE) && start;
    // div_done takes priority over an expiring watchdog on the same edge.
    assign expire = (state == WAIT) && !div_done && (cnt == CNT_LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = b_zero ? EXC : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (div_done)    state_nx = FIXUP;
                     else if (expire) state_nx = IDLE;
            FIXUP:   state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            EXC:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            div_a       <= '0;
            div_b       <= '0;
            q_raw       <= '0;
            r_raw       <= '0;
            hi_out      <= '0;
            lo_out      <= '0;
            div_start   <= 1'b0;
            busy        <= 1'b0;
            hilo_write  <= 1'b0;
            done        <= 1'b0;
            Div0        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            // Pulses are decoded from the next state so each one is high
            // exactly during the cycle spent in its state.
            div_start   <= (state_nx == ISSUE);
            busy        <= (state_nx != IDLE);
            hilo_write  <= (state_nx == WRITE);
            done        <= (state_nx == WRITE);
            Div0        <= (state_nx == EXC);
            err_timeout <= expire;

            if (accept && !b_zero) begin
                sa    <= A[WIDTH-1];
                sb    <= B[WIDTH-1];
                div_a <= abs_a;
                div_b <= abs_b;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if ((state == WAIT) && div_done) begin
                q_raw <= div_lo;
                r_raw <= div_hi;
            end

            if (state == FIXUP) begin
                lo_out <= q_adj;
                hi_out <= r_adj;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         div_done = 1'b0;
    logic [W-1:0] div_hi = '0;
    logic [W-1:0] div_lo = '0;
    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         busy;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         hilo_write;
    logic         done;
    logic         Div0;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    // Cumulative pulse counters, sampled on the falling edge.
    int m_dstart = 0, m_write = 0, m_done = 0, m_div0 = 0, m_tmo = 0;
    int s_dstart, s_write, s_done, s_div0, s_tmo;

    div_seq dut (
        .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
        .busy(busy), .hi_out(hi_out), .lo_out(lo_out),
        .hilo_write(hilo_write), .done(done), .Div0(Div0),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        m_dstart <= m_dstart + int'(div_start);
        m_write  <= m_write  + int'(hilo_write);
        m_done   <= m_done   + int'(done);
        m_div0   <= m_div0   + int'(Div0);
        m_tmo    <= m_tmo    + int'(err_timeout);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic snap();
        s_dstart = m_dstart; s_write = m_write; s_done = m_done;
        s_div0 = m_div0; s_tmo = m_tmo;
    endtask

    // Signed division semantics: truncate toward zero, remainder takes the
    // dividend's sign, results reduced mod 2^32.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa_l = longint'($signed(a));
        longint sb_l = longint'($signed(b));
        q = W'(sa_l / sb_l);
        r = W'(sa_l % sb_l);
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        longint v = longint'($signed(x));
        if (v < 0) v = -v;
        return W'(v);
    endfunction

    // Runs one operation, acting as a fixed-latency unsigned divider core.
    // lat = WAIT edges up to and including the one that samples div_done.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input bit poke,
                          output logic [W-1:0] da, output logic [W-1:0] db,
                          output int wr_edge, output logic done_at);
        snap();
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        da = div_a; db = div_b;
        tick();
        for (int i = 1; i < lat; i++) begin
            if (poke && i == 2) begin
                start = 1'b1; A = 32'd5; B = '0;
            end
            tick();
            start = 1'b0;
        end
        div_done = 1'b1;
        div_lo   = (db == '0) ? '1 : da / db;
        div_hi   = (db == '0) ? da : da % db;
        tick();
        div_done = 1'b0;
        div_lo   = $urandom;
        div_hi   = $urandom;
        wr_edge  = -1;
        done_at  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (hilo_write && wr_edge < 0) begin
                wr_edge = k;
                done_at = done;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        A = 32'h1234_5678; B = 32'h9; start = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, div_start, hilo_write, done, Div0, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {busy, div_start, hilo_write, done, Div0, err_timeout});
        end
        checks++;
        if ({hi_out, lo_out, div_a, div_b} !== '0) begin
            errors++;
            $display("FAIL reset_data hi=%h lo=%h da=%h db=%h expected all 0",
                     hi_out, lo_out, div_a, div_b);
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_sign_cases();
        logic [W-1:0] ta [4] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [W-1:0] tb [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [W-1:0] tq [4] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
        logic [W-1:0] tr [4] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [W-1:0] ea [4] = '{32'd7, 32'd7, 32'd7, 32'h8000_0000};
        logic [W-1:0] eb [4] = '{32'd2, 32'd2, 32'd2, 32'd1};
        logic [W-1:0] da, db;
        int we;
        logic dn;
        for (int i = 0; i < 4; i++) begin
            do_div(ta[i], tb[i], LAT, 1'b0, da, db, we, dn);
            checks++;
            if (da !== ea[i] || db !== eb[i]) begin
                errors++;
                $display("FAIL sign_operands[%0d] div_a=%h div_b=%h expected %h %h",
                         i, da, db, ea[i], eb[i]);
            end
            checks++;
            if (lo_out !== tq[i] || hi_out !== tr[i]) begin
                errors++;
                $display("FAIL sign_result[%0d] lo=%h hi=%h expected lo=%h hi=%h",
                         i, lo_out, hi_out, tq[i], tr[i]);
            end
            checks++;
            if (we !== 1 || dn !== 1'b1 || (m_write - s_write) !== 1 || (m_done - s_done) !== 1) begin
                errors++;
                $display("FAIL sign_write[%0d] edge=%0d done_at=%b writes=%0d dones=%0d expected 1 1 1 1",
                         i, we, dn, m_write - s_write, m_done - s_done);
            end
            checks++;
            if ((m_dstart - s_dstart) !== 1 || (m_div0 - s_div0) !== 0 || (m_tmo - s_tmo) !== 0) begin
                errors++;
                $display("FAIL sign_pulses[%0d] dstart=%0d div0=%0d tmo=%0d expected 1 0 0",
                         i, m_dstart - s_dstart, m_div0 - s_div0, m_tmo - s_tmo);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er, da, db;
        int we;
        logic dn;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? W'($signed(32'($urandom_range(0, 30)) - 32'sd15)) : $urandom;
            if (b == '0) b = 32'd3;
            ref_div(a, b, eq, er);
            do_div(a, b, LAT, 1'b0, da, db, we, dn);
            checks++;
            if (da !== mag(a) || db !== mag(b)) begin
                errors++;
                $display("FAIL rand_operands[%0d] div_a=%h div_b=%h expected %h %h",
                         i, da, db, mag(a), mag(b));
            end
            checks++;
            if (lo_out !== eq || hi_out !== er || we !== 1) begin
                errors++;
                $display("FAIL rand_result[%0d] A=%h B=%h lo=%h hi=%h edge=%0d expected lo=%h hi=%h edge=1",
                         i, a, b, lo_out, hi_out, we, eq, er);
            end
        end
    endtask

    task automatic test_div0();
        logic [W-1:0] plo, phi;
        plo = lo_out; phi = hi_out;
        snap();
        A = 32'd5; B = '0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (Div0 !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL div0_pulse Div0=%b busy=%b expected 1 1", Div0, busy);
        end
        tick();
        checks++;
        if (Div0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL div0_end Div0=%b busy=%b expected 0 0", Div0, busy);
        end
        tick();
        checks++;
        if ((m_dstart - s_dstart) !== 0 || (m_write - s_write) !== 0 || (m_div0 - s_div0) !== 1) begin
            errors++;
            $display("FAIL div0_side dstart=%0d writes=%0d div0=%0d expected 0 0 1",
                     m_dstart - s_dstart, m_write - s_write, m_div0 - s_div0);
        end
        checks++;
        if (lo_out !== plo || hi_out !== phi) begin
            errors++;
            $display("FAIL div0_hold lo=%h hi=%h expected %h %h", lo_out, hi_out, plo, phi);
        end
    endtask

    task automatic test_start_held();
        A = 32'd3; B = '0; start = 1'b1;
        tick();
        checks++;
        if (Div0 !== 1'b1) begin
            errors++;
            $display("FAIL held_first Div0=%b expected 1", Div0);
        end
        tick();
        checks++;
        if (Div0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle Div0=%b busy=%b expected 0 0", Div0, busy);
        end
        tick();
        checks++;
        if (Div0 !== 1'b1) begin
            errors++;
            $display("FAIL held_restart Div0=%b expected 1", Div0);
        end
        start = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] da, db;
        int we;
        logic dn;
        do_div(32'd100, 32'd7, LAT, 1'b1, da, db, we, dn);
        checks++;
        if (lo_out !== 32'd14 || hi_out !== 32'd2 || we !== 1) begin
            errors++;
            $display("FAIL busy_result lo=%h hi=%h edge=%0d expected 0000000e 00000002 1",
                     lo_out, hi_out, we);
        end
        checks++;
        if ((m_dstart - s_dstart) !== 1 || (m_div0 - s_div0) !== 0 || (m_write - s_write) !== 1) begin
            errors++;
            $display("FAIL busy_ignore dstart=%0d div0=%0d writes=%0d expected 1 0 1",
                     m_dstart - s_dstart, m_div0 - s_div0, m_write - s_write);
        end
    endtask

    task automatic test_done_at_limit();
        logic [W-1:0] da, db, eq, er;
        int we;
        logic dn;
        ref_div(32'hFFFF_FF9C, 32'd7, eq, er);
        do_div(32'hFFFF_FF9C, 32'd7, 40, 1'b0, da, db, we, dn);
        checks++;
        if (lo_out !== eq || hi_out !== er || we !== 1 || (m_tmo - s_tmo) !== 0) begin
            errors++;
            $display("FAIL limit_done lo=%h hi=%h edge=%0d tmo=%0d expected %h %h 1 0",
                     lo_out, hi_out, we, m_tmo - s_tmo, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        A = 32'd50; B = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, div_start, hilo_write, done, Div0, err_timeout} !== 6'b0 ||
            {hi_out, lo_out, div_a, div_b} !== '0) begin
            errors++;
            $display("FAIL midreset_clear busy=%b hi=%h lo=%h da=%h db=%h expected all 0",
                     busy, hi_out, lo_out, div_a, div_b);
        end
        tick();
        reset = 1'b1;
        snap();
        repeat (25) tick();
        div_done = 1'b1; div_lo = 32'd16; div_hi = 32'd2;
        tick();
        div_done = 1'b0;
        repeat (4) tick();
        checks++;
        if ((m_write - s_write) !== 0 || (m_done - s_done) !== 0 || busy !== 1'b0 ||
            lo_out !== '0 || hi_out !== '0) begin
            errors++;
            $display("FAIL midreset_late writes=%0d dones=%0d busy=%b lo=%h hi=%h expected 0 0 0 0 0",
                     m_write - s_write, m_done - s_done, busy, lo_out, hi_out);
        end
    endtask

    task automatic test_timeout();
        int edge_k;
        snap();
        A = 32'd9; B = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        edge_k = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (err_timeout && edge_k < 0) edge_k = k;
        end
        checks++;
        if (edge_k !== 41) begin
            errors++;
            $display("FAIL timeout_edge got %0d expected 41", edge_k);
        end
        checks++;
        if ((m_tmo - s_tmo) !== 1 || (m_write - s_write) !== 0 || busy !== 1'b0 ||
            lo_out !== '0 || hi_out !== '0) begin
            errors++;
            $display("FAIL timeout_side tmo=%0d writes=%0d busy=%b lo=%h hi=%h expected 1 0 0 0 0",
                     m_tmo - s_tmo, m_write - s_write, busy, lo_out, hi_out);
        end
    endtask

    initial begin
        test_reset();
        test_sign_cases();
        test_random();
        test_div0();
        test_start_held();
        test_start_while_busy();
        test_done_at_limit();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
